multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS-subset datapath. It decodes OP/Func from the instruction register and sequences the shared ALU, memory port, register file and PC across FETCH/DECODE/EXEC/MEM/WB steps. It waits on a memory-ready handshake and flags illegal opcodes. It sits beside the datapath and drives every mux select and write enable.

Parameters:
STATE_W, 4, width of the state register and the state debug output.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
OP  in  6  IR[31:26], stable from DECODE onward
Func  in  6  IR[5:0]
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  2  {bne,beq}; PC loads if (beq&Zero)|(bne&~Zero)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  write-back data select: 1=MDR
RegDst  out  1  destination register select: 1=rd, 0=rt
RegWrite  out  1  register file write
ALUsrcA  out  2  00=PC, 01=A(rs), 10=shamt
ALUsrcB  out  2  00=B, 01=const 4, 10=ext imm, 11=sext imm<<2
ExtZero  out  1  immediate extension: 1=zero-extend (andi/ori), 0=sign-extend
ALUop  out  3  000 add, 001 sub, 010 funct-decode, 100 and, 101 or
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
instr_done  out  1  one-cycle pulse on an instruction's final cycle
illegal  out  1  one-cycle pulse: unsupported OP/Func seen in DECODE
state  out  4  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- rst high: state=FETCH asynchronously. All outputs are forced 0, including MemRead, PCWrite, instr_done and illegal, for as long as rst is high.
- Reset mid-instruction: the instruction is abandoned with no write; the first cycle after release is a FETCH.
- Outputs are combinational from state, mem_ready and the decoded OP/Func.
- FETCH: MemRead=1, IorD=0, ALUsrcA=00, ALUsrcB=01, ALUop=000, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUsrcA=00, ALUsrcB=11, ALUop=000 (branch target precompute). Next state by class:
  lw/sw -> MEMADR; R-type -> EXEC; beq/bne -> BRANCH; j -> JUMP; addi/andi/ori -> IEXEC.
  Illegal opcode, or R-type with Func outside {00,02,03,20,22,24,25}: illegal=1, instr_done=1, next state FETCH, no writes.
- MEMADR: ALUsrcA=01, ALUsrcB=10, ExtZero=0, ALUop=000. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, next FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds while mem_ready=0; instr_done=mem_ready; goes to FETCH when mem_ready=1.
- EXEC: ALUop=010, ALUsrcB=00. ALUsrcA=10 for sll/srl/sra, otherwise 01. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, next FETCH.
- BRANCH: ALUsrcA=01, ALUsrcB=00, ALUop=001, PCSource=01, PCWriteCond={bne,beq}, instr_done=1, next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1, next FETCH.
- IEXEC: ALUsrcA=01, ALUsrcB=10. addi: ALUop=000, ExtZero=0. andi: ALUop=100, ExtZero=1. ori: ALUop=101, ExtZero=1. Next IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, next FETCH.
- Latency with mem_ready held 1 (cycles, FETCH to instr_done inclusive): lw 5; sw, R-type and I-type ALU 4; beq/bne/j 3; illegal 2.
- Each wait cycle with mem_ready=0 adds one cycle. No timeout.
- Any output not listed for a state is 0.

Decomposition:
- Shared package holds: state encodings; opcode constants (LW=23, SW=2B, BEQ=04, BNE=05, ADDI=08, ANDI=0C, ORI=0D, J=02, RTYPE=00); funct constants; ALUop codes; ALUsrcA/ALUsrcB/PCSource select codes.
- One sub-module, insn_class_decode: combinational OP/Func decode to one-hot class flags (is_r, is_shift, is_lw, is_sw, is_beq, is_bne, is_j, is_addi, is_andi, is_ori, is_illegal).

Test Plan:
- lw (OP=23), mem_ready=1 throughout -> state sequence 0,1,2,3,4. IRWrite only in cycle 1; RegWrite=MemtoReg=1 only in cycle 5; instr_done on cycle 5.
- sw (OP=2B), mem_ready low for 3 cycles in FETCH and 2 cycles in MEMWR -> IRWrite/PCWrite only when mem_ready=1. MemWrite held for 3 cycles; instr_done with the final MemWrite; total 9 cycles.
- bne (OP=05) -> BRANCH with PCWriteCond=2'b10, ALUop=001, PCSource=01. beq (OP=04) -> PCWriteCond=2'b01. Both 3 cycles.
- R-type sra (Func=03) -> EXEC has ALUsrcA=10, ALUop=010. R-type sub (Func=22) -> ALUsrcA=01. RWB has RegDst=1, RegWrite=1.
- ori (OP=0D) -> IEXEC has ALUop=101, ExtZero=1, ALUsrcB=10. OP=3F, or R-type with Func=08 -> illegal and instr_done pulse in DECODE, back to FETCH, zero writes.
- Assert rst asynchronously in MEMRD mid-lw -> state=0 immediately, all outputs 0 during reset, no RegWrite. After release, fetch restarts and the next lw completes normally.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// funct codes and datapath select values.
package multi_cycle_ctrl_pkg;

    localparam int unsigned ST_W    = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNC_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNC_W-1:0] FN_SRA = 6'h03;
    localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;

    localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_REG    = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_SHAMT  = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BRANCH = 2'b11;
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_class_decode.sv
// Combinational OP/Func decode into one-hot instruction class flags.
module insn_class_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       is_r,
    output logic       is_shift,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_j,
    output logic       is_addi,
    output logic       is_andi,
    output logic       is_ori,
    output logic       is_illegal
);

    logic func_shift;
    logic func_ok;

    always_comb begin
        func_shift = (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
        func_ok    = func_shift || (func == FN_ADD) || (func == FN_SUB) ||
                     (func == FN_AND) || (func == FN_OR);
    end

    always_comb begin
        is_r       = 1'b0;
        is_shift   = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_addi    = 1'b0;
        is_andi    = 1'b0;
        is_ori     = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                is_r       = func_ok;
                is_shift   = func_ok && func_shift;
                is_illegal = !func_ok;
            end
            OP_LW:   is_lw   = 1'b1;
            OP_SW:   is_sw   = 1'b1;
            OP_BEQ:  is_beq  = 1'b1;
            OP_BNE:  is_bne  = 1'b1;
            OP_J:    is_j    = 1'b1;
            OP_ADDI: is_addi = 1'b1;
            OP_ANDI: is_andi = 1'b1;
            OP_ORI:  is_ori  = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: sequences ALU, memory, register file and PC for the
// MIPS-subset datapath; outputs are combinational from state and decode.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         OP,
    input  logic [5:0]         Func,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic [1:0]         PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic [1:0]         ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic               ExtZero,
    output logic [2:0]         ALUop,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e cur;
    state_e nxt;
    logic is_r, is_shift, is_lw, is_sw, is_beq, is_bne, is_j;
    logic is_addi, is_andi, is_ori, is_illegal;

    insn_class_decode u_decode (
        .op         (OP),
        .func       (Func),
        .is_r       (is_r),
        .is_shift   (is_shift),
        .is_lw      (is_lw),
        .is_sw      (is_sw),
        .is_beq     (is_beq),
        .is_bne     (is_bne),
        .is_j       (is_j),
        .is_addi    (is_addi),
        .is_andi    (is_andi),
        .is_ori     (is_ori),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    // Memory states hold until mem_ready; unused codes fall back to FETCH.
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                if (is_illegal)                        nxt = S_FETCH;
                else if (is_lw || is_sw)               nxt = S_MEMADR;
                else if (is_r)                         nxt = S_EXEC;
                else if (is_beq || is_bne)             nxt = S_BRANCH;
                else if (is_j)                         nxt = S_JUMP;
                else if (is_addi || is_andi || is_ori) nxt = S_IEXEC;
                else                                   nxt = S_FETCH;
            end
            S_MEMADR: nxt = is_lw ? S_MEMRD : (is_sw ? S_MEMWR : S_FETCH);
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH;
            S_EXEC:   nxt = S_RWB;
            S_IEXEC:  nxt = S_IWB;
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUsrcA     = SRCA_PC;
        ALUsrcB     = SRCB_REG;
        ExtZero     = 1'b0;
        ALUop       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUsrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUsrcB    = SRCB_BRANCH;
                    illegal    = is_illegal;
                    instr_done = is_illegal;
                end
                S_MEMADR: begin
                    ALUsrcA = SRCA_REG;
                    ALUsrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    ALUop   = ALU_FUNCT;
                    ALUsrcA = is_shift ? SRCA_SHAMT : SRCA_REG;
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUsrcA     = SRCA_REG;
                    ALUop       = ALU_SUB;
                    PCSource    = PCSRC_ALUOUT;
                    PCWriteCond = {is_bne, is_beq};
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_IEXEC: begin
                    ALUsrcA = SRCA_REG;
                    ALUsrcB = SRCB_IMM;
                    ExtZero = is_andi || is_ori;
                    ALUop   = is_andi ? ALU_AND : (is_ori ? ALU_OR : ALU_ADD);
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = STATE_W'(cur);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction expected cycle
// traces are built from the instruction's phase list and compared every cycle.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OP, Func;
    logic       mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
    logic       ExtZero, instr_done, illegal;
    logic [1:0] PCWriteCond, ALUsrcA, ALUsrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcwc;
        logic       iord, mrd, mwr, irw, m2r, rdst, rw;
        logic [1:0] sa, sb;
        logic       ez;
        logic [2:0] aop;
        logic [1:0] psrc;
        logic       done, ill;
    } obs_t;

    obs_t exp_q[$];
    bit   mr_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    multi_cycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .OP(OP), .Func(Func), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ExtZero(ExtZero), .ALUop(ALUop),
        .PCSource(PCSource), .instr_done(instr_done), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.st = state;     o.pcw = PCWrite;   o.pcwc = PCWriteCond;
        o.iord = IorD;    o.mrd = MemRead;   o.mwr = MemWrite;
        o.irw = IRWrite;  o.m2r = MemtoReg;  o.rdst = RegDst;  o.rw = RegWrite;
        o.sa = ALUsrcA;   o.sb = ALUsrcB;    o.ez = ExtZero;   o.aop = ALUop;
        o.psrc = PCSource; o.done = instr_done; o.ill = illegal;
        return o;
    endfunction

    function automatic obs_t idle(input logic [3:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic push(input obs_t o, input bit mr);
        exp_q.push_back(o);
        mr_q.push_back(mr);
    endtask

    // Expected trace of one instruction: fetch, decode, then the class's phases.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        obs_t o;
        bit   shift, r_ok, bad;
        exp_q.delete();
        mr_q.delete();
        o = idle(4'd0); o.mrd = 1; o.sb = 2'b01;
        for (int i = 0; i < fw; i++) push(o, 1'b0);
        o.irw = 1; o.pcw = 1;
        push(o, 1'b1);
        shift = (fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03);
        r_ok  = shift || (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25);
        bad   = !(op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D}) &&
                !(op == 6'h00 && r_ok);
        o = idle(4'd1); o.sb = 2'b11;
        if (bad) begin
            o.ill = 1; o.done = 1;
            push(o, rb());
        end else begin
            push(o, rb());
            if (op == 6'h23 || op == 6'h2B) begin
                o = idle(4'd2); o.sa = 2'b01; o.sb = 2'b10;
                push(o, rb());
                if (op == 6'h23) begin
                    o = idle(4'd3); o.mrd = 1; o.iord = 1;
                    for (int i = 0; i < mw; i++) push(o, 1'b0);
                    push(o, 1'b1);
                    o = idle(4'd4); o.rw = 1; o.m2r = 1; o.done = 1;
                    push(o, rb());
                end else begin
                    o = idle(4'd5); o.mwr = 1; o.iord = 1;
                    for (int i = 0; i < mw; i++) push(o, 1'b0);
                    o.done = 1;
                    push(o, 1'b1);
                end
            end else if (op == 6'h00) begin
                o = idle(4'd6); o.aop = 3'b010; o.sa = shift ? 2'b10 : 2'b01;
                push(o, rb());
                o = idle(4'd7); o.rw = 1; o.rdst = 1; o.done = 1;
                push(o, rb());
            end else if (op == 6'h04 || op == 6'h05) begin
                o = idle(4'd8); o.sa = 2'b01; o.aop = 3'b001; o.psrc = 2'b01; o.done = 1;
                o.pcwc = (op == 6'h05) ? 2'b10 : 2'b01;
                push(o, rb());
            end else if (op == 6'h02) begin
                o = idle(4'd9); o.pcw = 1; o.psrc = 2'b10; o.done = 1;
                push(o, rb());
            end else begin
                o = idle(4'd10); o.sa = 2'b01; o.sb = 2'b10;
                o.aop = (op == 6'h08) ? 3'b000 : ((op == 6'h0C) ? 3'b100 : 3'b101);
                o.ez  = (op != 6'h08);
                push(o, rb());
                o = idle(4'd11); o.rw = 1; o.done = 1;
                push(o, rb());
            end
        end
    endtask

    // Plays up to 'limit' expected cycles; entered and left at posedge+1.
    task automatic run_q(input string name, input int limit, output int done_at);
        obs_t got;
        done_at = -1;
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            mem_ready = mr_q[i];
            #1;
            got = observe();
            n_cmp++;
            if (got !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h required %h", name, i, got, exp_q[i]);
            end
            if (got.done === 1'b1 && done_at < 0) done_at = i + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_insn(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input int lat);
        int d;
        OP = op;
        Func = fn;
        build(op, fn, fw, mw);
        run_q(name, 1000, d);
        if (lat > 0) begin
            n_cmp++;
            if (d !== lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d required %0d", name, d, lat);
            end
        end
    endtask

    task automatic check_zero(input string name);
        obs_t got;
        got = observe();
        n_cmp++;
        if (got !== obs_t'('0)) begin
            n_bad++;
            $display("FAIL %s: got %h required 0", name, got);
        end
    endtask

    task automatic test_reset();
        rst = 1; mem_ready = 1; OP = 6'h23; Func = 6'h00;
        #3;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        mem_ready = 0;
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        run_insn("lw", 6'h23, 6'h00, 0, 0, 5);
    endtask

    task automatic test_sw();
        run_insn("sw_waits", 6'h2B, 6'h11, 3, 2, 9);
    endtask

    task automatic test_branch();
        run_insn("bne", 6'h05, 6'h00, 0, 0, 3);
        run_insn("beq", 6'h04, 6'h00, 0, 0, 3);
        run_insn("j", 6'h02, 6'h00, 1, 0, 4);
    endtask

    task automatic test_rtype();
        run_insn("sra", 6'h00, 6'h03, 0, 0, 4);
        run_insn("sub", 6'h00, 6'h22, 0, 0, 4);
        run_insn("sll", 6'h00, 6'h00, 0, 0, 4);
    endtask

    task automatic test_itype();
        run_insn("ori", 6'h0D, 6'h00, 0, 0, 4);
        run_insn("andi", 6'h0C, 6'h00, 0, 0, 4);
        run_insn("addi", 6'h08, 6'h00, 0, 0, 4);
    endtask

    task automatic test_illegal();
        run_insn("illegal_op", 6'h3F, 6'h00, 0, 0, 2);
        run_insn("illegal_func", 6'h00, 6'h08, 0, 0, 2);
    endtask

    task automatic test_reset_mid();
        int d;
        OP = 6'h23; Func = 6'h00;
        build(6'h23, 6'h00, 1, 2);
        run_q("lw_pre_reset", 4, d);
        mem_ready = 0;
        #1;
        rst = 1;
        #1;
        check_zero("reset_mid_async");
        mem_ready = 1;
        @(posedge clk);
        #1;
        check_zero("reset_mid_held");
        mem_ready = 0;
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
        run_insn("lw_after_reset", 6'h23, 6'h00, 0, 0, 5);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[11] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                                6'h0C, 6'h0D, 6'h00, 6'h00, 6'h3F};
        logic [5:0] fns[7]  = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h25};
        logic [5:0] op, fn;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            run_insn("random", op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_rtype();
        test_itype();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
